// File: rtl/mem_arbiter.sv
// mem_arbiter
// Lets the CPU core and one video/DMA fetch requester share the single-port
// system memory (1 MB, one-cycle registered read). Every access takes two
// cycles: an address cycle, then a data cycle. Video has priority, but after
// MAX_VID_BURST back-to-back video accesses the CPU is always granted one
// access, so the CPU cannot be starved.
//
// Optional build macro: MEM_ARB_VID_WRITE_EN
//   defined   : vid_we / vid_wdata ports exist and video may write in V_ADDR
//   undefined : video accesses are read-only (we=0 and out=0 in V_* states)
//
// Ports
//   clock, reset_n           system clock, async active-low reset
//   cpu_address/out/we       CPU bus request (held while cpu_ce=0)
//   cpu_in, cpu_ce           CPU read data and clock enable
//   vid_req, vid_address     video request (level) and address
//   vid_ack, vid_data        video completion pulse and read data
//   address, out, we, in     memory array port
//
// state  | meaning
// C_ADDR | CPU address/write cycle
// C_DATA | CPU data cycle, cpu_ce=1, arbitration decision
// V_ADDR | video address (and optional write) cycle
// V_DATA | video data cycle, vid_ack=1, arbitration decision

module mem_arbiter #(
  parameter int MAX_VID_BURST = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_ce,
  input  logic        vid_req,
  input  logic [19:0] vid_address,
`ifdef MEM_ARB_VID_WRITE_EN
  input  logic        vid_we,
  input  logic [7:0]  vid_wdata,
`endif
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  output logic [19:0] address,
  output logic [7:0]  out,
  output logic        we,
  input  logic [7:0]  in
);

  typedef enum logic [1:0] {C_ADDR, C_DATA, V_ADDR, V_DATA} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_VID_BURST);

  state_t     state;
  logic [3:0] vcnt;
  logic       sel_vid;
  logic       grant_vid;

  // Only meaningful in the data cycles; a full budget always hands the next
  // slot to the CPU even while video is still requesting.
  assign grant_vid = vid_req && (vcnt < BURST_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= C_ADDR;
      vcnt    <= 4'd0;
      cpu_ce  <= 1'b0;
      vid_ack <= 1'b0;
    end else begin
      case (state)
        C_ADDR: begin
          state   <= C_DATA;
          cpu_ce  <= 1'b1;
          vid_ack <= 1'b0;
        end
        V_ADDR: begin
          state   <= V_DATA;
          cpu_ce  <= 1'b0;
          vid_ack <= 1'b1;
        end
        default: begin
          cpu_ce  <= 1'b0;
          vid_ack <= 1'b0;
          if (grant_vid) begin
            state <= V_ADDR;
            vcnt  <= vcnt + 4'd1;
          end else begin
            state <= C_ADDR;
            vcnt  <= 4'd0;
          end
        end
      endcase
    end
  end

  assign sel_vid = (state == V_ADDR) || (state == V_DATA);

  assign address  = sel_vid ? vid_address : cpu_address;
  assign cpu_in   = in;
  assign vid_data = in;

  // Write enable is combinational off the CPU/video strobe so it tracks the
  // request presented in the address cycle; gating with reset_n kills an
  // in-flight write the moment reset is asserted (state alone resets to
  // C_ADDR, which would otherwise pass cpu_we through).
`ifdef MEM_ARB_VID_WRITE_EN
  assign out = sel_vid ? vid_wdata : cpu_out;
  assign we  = reset_n && (((state == C_ADDR) && cpu_we) ||
                           ((state == V_ADDR) && vid_we));
`else
  assign out = sel_vid ? 8'h00 : cpu_out;
  assign we  = reset_n && (state == C_ADDR) && cpu_we;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] cpu_address, vid_address, address;
  logic [7:0]  cpu_out, cpu_in, vid_data, out, mem_rd;
  logic        cpu_we, cpu_ce, vid_req, vid_ack, we;
`ifdef MEM_ARB_VID_WRITE_EN
  logic        vid_we;
  logic [7:0]  vid_wdata;
`endif

  logic [7:0] mem     [0:1048575];
  logic [7:0] ref_mem [0:1048575];

  mem_arbiter #(.MAX_VID_BURST(MAXB)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_in(cpu_in), .cpu_ce(cpu_ce),
    .vid_req(vid_req), .vid_address(vid_address),
`ifdef MEM_ARB_VID_WRITE_EN
    .vid_we(vid_we), .vid_wdata(vid_wdata),
`endif
    .vid_ack(vid_ack), .vid_data(vid_data),
    .address(address), .out(out), .we(we), .in(mem_rd)
  );

  always #5 clock = ~clock;

  // memory array: one-cycle registered read, read-before-write
  always @(posedge clock) begin
    mem_rd <= mem[address];
    if (we) mem[address] <= out;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: slot-level view of the schedule
  int         m_vid;    // owner of current slot: 0 cpu, 1 video
  int         m_ph;     // 0 address cycle, 1 data cycle
  int         m_burst;  // consecutive video slots granted so far
  logic [7:0] m_rd;     // data the memory will return in the data cycle
  int         mode;     // 0 random video, 1 video held high, 2 video idle
  int         cpu_seq;
  int         cnt_ce, cnt_ack;

  function automatic logic [19:0] pick_addr();
    logic [19:0] base;
    case ($urandom_range(0, 2))
      0:       base = 20'h00000;
      1:       base = 20'hBF0F0;
      default: base = 20'hB8000;
    endcase
    return base | 20'($urandom_range(0, 7));
  endfunction

  task automatic new_cpu_txn();
    if (cpu_seq < 4) begin
      cpu_address = 20'(cpu_seq); cpu_we = 1'b0; cpu_out = 8'h00;
    end else if (cpu_seq == 4) begin
      cpu_address = 20'hBF0F1; cpu_we = 1'b1; cpu_out = 8'h56;
    end else if (cpu_seq == 5) begin
      cpu_address = 20'hBF0F1; cpu_we = 1'b0; cpu_out = 8'h00;
    end else begin
      cpu_address = pick_addr();
      cpu_we = ($urandom_range(0, 2) == 0);
      cpu_out = 8'($urandom);
    end
    cpu_seq++;
  endtask

  task automatic model_reset();
    m_vid = 0; m_ph = 0; m_burst = 0;
  endtask

  // check the current cycle, drive next inputs, advance the model
  task automatic eval();
    logic       e_we;
    logic [19:0] e_addr;
    logic [7:0] e_out, vw_data;
    logic       vw;
`ifdef MEM_ARB_VID_WRITE_EN
    vw = vid_we; vw_data = vid_wdata;
`else
    vw = 1'b0; vw_data = 8'h00;
`endif
    e_addr = (m_vid == 1) ? vid_address : cpu_address;
    e_out  = (m_vid == 1) ? vw_data : cpu_out;
    e_we   = (m_ph == 0) ? ((m_vid == 1) ? vw : cpu_we) : 1'b0;
    check("cpu_ce", cpu_ce, (m_vid == 0 && m_ph == 1));
    check("vid_ack", vid_ack, (m_vid == 1 && m_ph == 1));
    check("we", we, e_we);
    check("address", address, e_addr);
    check("out", out, e_out);
    if (m_ph == 1) begin
      if (m_vid == 1) check("vid_data", vid_data, m_rd);
      else            check("cpu_in", cpu_in, m_rd);
    end else begin
      m_rd = ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] = e_out;
    end
    if (cpu_ce) cnt_ce++;
    if (vid_ack) cnt_ack++;
    // drive next inputs
    if (m_vid == 0 && m_ph == 1) new_cpu_txn();
    case (mode)
      1: vid_req = 1'b1;
      2: vid_req = 1'b0;
      default: vid_req = ($urandom_range(0, 2) != 0);
    endcase
    if (mode == 0 && !(m_vid == 1 && m_ph == 0) && $urandom_range(0, 3) == 0) begin
      vid_address = pick_addr();
`ifdef MEM_ARB_VID_WRITE_EN
      vid_we = ($urandom_range(0, 2) == 0);
      vid_wdata = 8'($urandom);
`endif
    end
    // advance
    if (m_ph == 0) m_ph = 1;
    else begin
      m_ph = 0;
      if (vid_req && m_burst < MAXB) begin m_vid = 1; m_burst++; end
      else begin m_vid = 0; m_burst = 0; end
    end
  endtask

  task automatic step();
    @(negedge clock);
    eval();
  endtask

  initial begin
    logic [19:0] tgt;
    logic        found;
    for (int i = 0; i < 1048576; i++) begin
      mem[i]     = 8'(i ^ (i >> 8));
      ref_mem[i] = 8'(i ^ (i >> 8));
    end
    cpu_seq = 0; cnt_ce = 0; cnt_ack = 0;
    mode = 2;
    vid_req = 1'b0; vid_address = 20'hB8000;
`ifdef MEM_ARB_VID_WRITE_EN
    vid_we = 1'b0; vid_wdata = 8'h00;
`endif
    new_cpu_txn();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_cpu_ce", cpu_ce, 1'b0);
    check("rst_vid_ack", vid_ack, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_address", address, cpu_address);

    // no video: directed CPU reads, write/readback, then random traffic
    reset_n = 1'b1;
    model_reset();
    eval();
    for (int i = 0; i < 30; i++) step();
    mode = 0;
    for (int i = 0; i < 3000; i++) step();

    // async reset in the middle of a video address cycle
    mode = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (m_vid == 1 && m_ph == 0) found = 1'b1;
      else eval();
    end
    check("reach_v_addr", found, 1'b1);
    tgt = vid_address;
`ifdef MEM_ARB_VID_WRITE_EN
    vid_we = 1'b1;
    vid_wdata = ~ref_mem[tgt];
    #1;
    check("v_addr_write", we, 1'b1);
`endif
    reset_n = 1'b0;
    #1;
    check("arst_we", we, 1'b0);
    check("arst_vid_ack", vid_ack, 1'b0);
    check("arst_cpu_ce", cpu_ce, 1'b0);
    check("arst_address", address, cpu_address);
    @(negedge clock);
    check("arst_hold_we", we, 1'b0);
    check("arst_hold_ack", vid_ack, 1'b0);
    check("arst_target", mem[tgt], ref_mem[tgt]);
`ifdef MEM_ARB_VID_WRITE_EN
    vid_we = 1'b0;
`endif

    // video held high: 4 acks then one CPU access, repeating
    vid_address = 20'hB8000;
    vid_req = 1'b1;
    cnt_ce = 0; cnt_ack = 0;
    reset_n = 1'b1;
    model_reset();
    eval();
    for (int i = 1; i < 50; i++) step();
    check("burst_ce_count", cnt_ce, 5);
    check("burst_ack_count", cnt_ack, 20);

    // random again to mix everything after the directed phases
    mode = 0;
    for (int i = 0; i < 1000; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
